// File: rtl/regfile_dump.sv
// regfile_dump
//   Walks a contiguous, wrapping range of register-file addresses after a
//   start pulse and streams each word out with its address and a last flag.
//
// Ports
//   clk, rst         : clock, synchronous active-high reset
//   start            : one-cycle dump request, honoured only in IDLE
//   start_addr, len  : first address and word count (0..2**ADDR_WIDTH),
//                      sampled with start
//   rf_raddr, rf_ren : read port towards the register file
//   rf_rdata         : combinational read data for rf_raddr
//   out_valid/ready  : output stream handshake
//   out_data/addr/last : captured word, its address, final-word flag
//   busy             : dump in progress (RUN or DRAIN)
//   done             : one-cycle pulse when a dump finishes
//   dbg_state        : current FSM state (0 IDLE, 1 RUN, 2 DRAIN)
//
// Handshake: a word transfers on a rising clk edge where out_valid and
// out_ready are both high. While out_valid is high and out_ready is low,
// out_data/out_addr/out_last hold stable and out_valid stays high.
module regfile_dump #(
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic [ADDR_WIDTH-1:0] rf_raddr,
  output logic                  rf_ren,
  input  logic [DATA_WIDTH-1:0] rf_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [ADDR_WIDTH:0]   remaining;

  // The output register can take a new word when it is empty or when its
  // current word is leaving on this edge.
  logic capture;
  assign capture = (state == RUN) && (!out_valid || out_ready);

  // Read address is only presented while actively reading; it holds during
  // a stall because cur_addr only advances on capture.
  assign rf_ren    = (state == RUN);
  assign rf_raddr  = (state == RUN) ? cur_addr : '0;
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (len != '0) begin
              state     <= RUN;
              cur_addr  <= start_addr;
              remaining <= len;
            end else begin
              // Empty dump: finish immediately without emitting anything.
              done <= 1'b1;
            end
          end
        end

        RUN: begin
          if (capture) begin
            out_valid <= 1'b1;
            out_data  <= rf_rdata;
            out_addr  <= cur_addr;
            out_last  <= (remaining == (ADDR_WIDTH+1)'(1));
            // Natural overflow wraps the address from all-ones to zero.
            cur_addr  <= cur_addr + ADDR_WIDTH'(1);
            remaining <= remaining - (ADDR_WIDTH+1)'(1);
            if (remaining == (ADDR_WIDTH+1)'(1)) begin
              state <= DRAIN;
            end
          end
        end

        DRAIN: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
            done      <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump with ADDR_WIDTH=3, DATA_WIDTH=8 and a
// register-file model holding rf[i] = 0x10 + i.
module tb_regfile_dump;

  localparam int AW = 3;
  localparam int DW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          start;
  logic [AW-1:0] start_addr;
  logic [AW:0]   len;
  logic [AW-1:0] rf_raddr;
  logic          rf_ren;
  logic [DW-1:0] rf_rdata;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          out_last;
  logic          busy;
  logic          done;
  logic [1:0]    dbg_state;

  logic [DW-1:0] rf [8];
  assign rf_rdata = rf[rf_raddr];

  regfile_dump #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .len        (len),
    .rf_raddr   (rf_raddr),
    .rf_ren     (rf_ren),
    .rf_rdata   (rf_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_addr   (out_addr),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard ----------------
  // Expected word packing: {last, addr, data}
  logic [AW+DW:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int t0       = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Words transfer on the next rising edge when valid and ready are both
  // high at the falling edge (inputs only change just after rising edges).
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", {20'd0, out_last, out_addr, out_data}, 32'hFFFF_FFFF);
      end else begin
        check("stream_word", {20'd0, out_last, out_addr, out_data}, {20'd0, exp_q.pop_front()});
      end
      check("no_done_with_valid", {31'd0, done}, 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push(input logic last, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_q.push_back({last, a, d});
  endtask

  task automatic do_start(input logic [AW-1:0] a, input logic [AW:0] l);
    start      = 1'b1;
    start_addr = a;
    len        = l;
    tick();
    start = 1'b0;
    t0    = cyc;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (done !== 1'b1 && n < budget);
    if (done !== 1'b1) check("done_timeout", 32'd0, 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int i = 0; i < 8; i++) rf[i] = 8'h10 + 8'(i);
    rst        = 1'b1;
    start      = 1'b0;
    start_addr = '0;
    len        = '0;
    out_ready  = 1'b1;
    tick();
    tick();

    // Reset state
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_rf_ren",    {31'd0, rf_ren},    32'd0);
    check("rst_busy",      {31'd0, busy},      32'd0);
    check("rst_done",      {31'd0, done},      32'd0);
    check("rst_state",     {30'd0, dbg_state}, 32'd0);
    rst = 1'b0;
    tick();

    // Basic dump: 2..4
    push(1'b0, 3'd2, 8'h12);
    push(1'b0, 3'd3, 8'h13);
    push(1'b1, 3'd4, 8'h14);
    do_start(3'd2, 4'd3);
    check("basic_busy",     {31'd0, busy},      32'd1);
    check("basic_rf_ren",   {31'd0, rf_ren},    32'd1);
    check("basic_rf_raddr", {29'd0, rf_raddr},  32'd2);
    check("basic_no_early", {31'd0, out_valid}, 32'd0);
    wait_done(20);
    check("basic_done_lat", cyc - t0, 32'd4);
    check("basic_done_busy", {31'd0, busy}, 32'd0);
    check("basic_done_valid", {31'd0, out_valid}, 32'd0);
    tick();
    check("basic_done_pulse", {31'd0, done}, 32'd0);

    // Wrap, full depth
    for (int i = 0; i < 8; i++) begin
      push(i == 7, 3'(6 + i), 8'h10 + 8'((6 + i) % 8));
    end
    do_start(3'd6, 4'd8);
    wait_done(30);
    check("wrap_done_lat", cyc - t0, 32'd9);
    check("wrap_q_empty", exp_q.size(), 32'd0);
    tick();

    // Backpressure on word (1,0x11)
    for (int i = 0; i < 4; i++) push(i == 3, 3'(i), 8'h10 + 8'(i));
    do_start(3'd0, 4'd4);
    tick();
    tick();
    out_ready = 1'b0;
    check("bp_word", {20'd0, out_last, out_addr, out_data}, {20'd0, 1'b0, 3'd1, 8'h11});
    for (int k = 0; k < 3; k++) begin
      tick();
      check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      check("bp_hold_word",  {20'd0, out_last, out_addr, out_data}, {20'd0, 1'b0, 3'd1, 8'h11});
      check("bp_hold_raddr", {28'd0, rf_ren, rf_raddr}, {28'd0, 1'b1, 3'd2});
    end
    out_ready = 1'b1;
    wait_done(30);
    check("bp_done_lat", cyc - t0, 32'd8);
    check("bp_q_empty", exp_q.size(), 32'd0);
    tick();

    // Zero length
    do_start(3'd1, 4'd0);
    check("zero_done",  {31'd0, done},      32'd1);
    check("zero_busy",  {31'd0, busy},      32'd0);
    check("zero_valid", {31'd0, out_valid}, 32'd0);
    tick();
    check("zero_done_clr", {31'd0, done},  32'd0);
    check("zero_valid2", {31'd0, out_valid}, 32'd0);

    // Start while busy is ignored
    for (int i = 0; i < 3; i++) push(i == 2, 3'(i), 8'h10 + 8'(i));
    do_start(3'd0, 4'd3);
    tick();
    start      = 1'b1;
    start_addr = 3'd5;
    len        = 4'd2;
    tick();
    start = 1'b0;
    wait_done(20);
    check("ign_done_lat", cyc - t0, 32'd4);
    tick();
    tick();
    check("ign_idle_valid", {31'd0, out_valid}, 32'd0);
    check("ign_q_empty", exp_q.size(), 32'd0);

    // Reset mid-dump after the 2nd word
    push(1'b0, 3'd0, 8'h10);
    push(1'b0, 3'd1, 8'h11);
    do_start(3'd0, 4'd5);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("mid_rst_outs", {8'd0, out_valid, out_last, out_data, out_addr, rf_raddr, rf_ren, busy, done},
          32'd0);
    check("mid_rst_state", {30'd0, dbg_state}, 32'd0);
    rst = 1'b0;
    tick();
    push(1'b1, 3'd0, 8'h10);
    do_start(3'd0, 4'd1);
    wait_done(20);
    check("post_rst_lat", cyc - t0, 32'd2);
    tick();

    // Write collision at address 3
    push(1'b1, 3'd3, 8'h13);
    do_start(3'd3, 4'd1);
    @(posedge clk);
    rf[3] <= 8'hAA;
    #1;
    cyc++;
    check("coll_data", {24'd0, out_data}, 32'h13);
    wait_done(20);
    tick();
    push(1'b1, 3'd3, 8'hAA);
    do_start(3'd3, 4'd1);
    wait_done(20);
    check("coll_later_lat", cyc - t0, 32'd2);
    tick();
    check("final_q_empty", exp_q.size(), 32'd0);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute safety net against a hung run.
  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
